// File: rtl/modem_ctrl.sv
// UART modem control/status block: MCR storage, synchronised MSR with sticky
// deltas and modem interrupt, RTS auto-flow hysteresis and CTS-gated TX starts.
module modem_ctrl #(
    parameter int RX_LVL_W    = 5,
    parameter int RTS_OFF_LVL = 14,
    parameter int RTS_ON_LVL  = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                mcr_we,
    input  logic [5:0]          mcr_wdata,
    output logic [5:0]          mcr,
    input  logic                msr_re,
    output logic [7:0]          msr_rdata,
    output logic                modem_int,
    input  logic [RX_LVL_W-1:0] rx_level,
    input  logic                tx_req,
    output logic                tx_start,
    input  logic                tx_done,
    output logic                tx_stalled,
    input  logic                nCTS,
    input  logic                nDSR,
    input  logic                nRI,
    input  logic                nDCD,
    output logic                nRTS,
    output logic                nDTR,
    output logic                OUT1,
    output logic                OUT2
);

    localparam logic [RX_LVL_W-1:0] offLvl = RX_LVL_W'(RTS_OFF_LVL);
    localparam logic [RX_LVL_W-1:0] onLvl  = RX_LVL_W'(RTS_ON_LVL);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        STALL
    } txState_t;

    logic       loopEn;
    logic       afeEn;
    logic [3:0] modemIn;     // {nDCD, nRI, nDSR, nCTS} after the loopback mux
    logic [3:0] syncMeta;
    logic [3:0] syncOut;
    logic [3:0] status;      // {DCD, RI, DSR, CTS}
    logic [3:0] prevStatus;
    logic [3:0] deltaSet;    // {DDCD, TERI, DDSR, DCTS}
    logic [3:0] deltaQ;
    logic       flowOk;
    logic       txAllow;
    txState_t   state;
    txState_t   nextState;
    logic       startNext;

    assign loopEn = mcr[4];
    assign afeEn  = mcr[5];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mcr <= 6'h00;
        end else if (mcr_we) begin
            mcr <= mcr_wdata;
        end
    end

    // Loopback feeds the synchronizer so both paths share the same latency.
    assign modemIn = loopEn ? ~{mcr[3], mcr[2], mcr[0], mcr[1]}
                            : {nDCD, nRI, nDSR, nCTS};

    assign status   = ~syncOut;
    assign deltaSet = {status[3] ^ prevStatus[3],
                       prevStatus[2] & ~status[2],
                       status[1] ^ prevStatus[1],
                       status[0] ^ prevStatus[0]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            syncMeta   <= 4'hF;
            syncOut    <= 4'hF;
            prevStatus <= 4'h0;
            deltaQ     <= 4'h0;
        end else begin
            syncMeta   <= modemIn;
            syncOut    <= syncMeta;
            prevStatus <= status;
            deltaQ     <= (deltaQ & ~{4{msr_re}}) | deltaSet;
        end
    end

    assign msr_rdata = {status, deltaQ};
    assign modem_int = |deltaQ;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flowOk <= 1'b1;
        end else if (!afeEn) begin
            flowOk <= 1'b1;
        end else if (rx_level >= offLvl) begin
            flowOk <= 1'b0;
        end else if (rx_level <= onLvl) begin
            flowOk <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            nRTS <= 1'b1;
            nDTR <= 1'b1;
            OUT1 <= 1'b1;
            OUT2 <= 1'b1;
        end else if (loopEn) begin
            nRTS <= 1'b1;
            nDTR <= 1'b1;
            OUT1 <= 1'b1;
            OUT2 <= 1'b1;
        end else begin
            nRTS <= ~(mcr[1] & flowOk);
            nDTR <= ~mcr[0];
            OUT1 <= ~mcr[2];
            OUT2 <= ~mcr[3];
        end
    end

    assign txAllow = ~afeEn | status[0];

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        nextState = state;
        startNext = 1'b0;
        case (state)
            IDLE: begin
                if (tx_req && txAllow) begin
                    startNext = 1'b1;
                    nextState = BUSY;
                end else if (tx_req) begin
                    nextState = STALL;
                end
            end
            BUSY: begin
                if (tx_done) begin
                    nextState = IDLE;
                end
            end
            STALL: begin
                if (txAllow || !tx_req) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            tx_start <= 1'b0;
        end else begin
            state    <= nextState;
            tx_start <= startNext;
        end
    end

    assign tx_stalled = (state == STALL);

endmodule

// File: tb/tb_modem_ctrl.sv
// Self-checking bench for modem_ctrl: MSR/delta timing, loopback, auto-RTS
// hysteresis and CTS-gated transmit starts tracked through a start scoreboard.
module tb_modem_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       mcr_we = 1'b0;
    logic [5:0] mcr_wdata = 6'h00;
    logic [5:0] mcr;
    logic       msr_re = 1'b0;
    logic [7:0] msr_rdata;
    logic       modem_int;
    logic [4:0] rx_level = 5'd0;
    logic       tx_req = 1'b0;
    logic       tx_start;
    logic       tx_done = 1'b0;
    logic       tx_stalled;
    logic       nCTS = 1'b1;
    logic       nDSR = 1'b1;
    logic       nRI = 1'b1;
    logic       nDCD = 1'b1;
    logic       nRTS;
    logic       nDTR;
    logic       OUT1;
    logic       OUT2;

    int   nChecks = 0;
    int   nPass = 0;
    int   expStartQ[$];
    logic prevStart = 1'b0;

    modem_ctrl #(.RX_LVL_W(5), .RTS_OFF_LVL(14), .RTS_ON_LVL(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .mcr_we(mcr_we), .mcr_wdata(mcr_wdata), .mcr(mcr),
        .msr_re(msr_re), .msr_rdata(msr_rdata), .modem_int(modem_int),
        .rx_level(rx_level), .tx_req(tx_req), .tx_start(tx_start),
        .tx_done(tx_done), .tx_stalled(tx_stalled),
        .nCTS(nCTS), .nDSR(nDSR), .nRI(nRI), .nDCD(nDCD),
        .nRTS(nRTS), .nDTR(nDTR), .OUT1(OUT1), .OUT2(OUT2)
    );

    always #5 CLK = ~CLK;

    // Start scoreboard: every observed pulse must match a pushed expectation.
    always @(negedge CLK) begin
        if (tx_start === 1'b1) begin
            nChecks++;
            if (prevStart)
                $display("FAIL tx_start_width: got high for 2+ cycles, required 1 cycle");
            else if (expStartQ.size() == 0)
                $display("FAIL tx_start_unexpected: got pulse, required none");
            else begin
                void'(expStartQ.pop_front());
                nPass++;
            end
        end
        prevStart = (tx_start === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required bench completion");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic write_mcr(input logic [5:0] v);
        mcr_we    = 1'b1;
        mcr_wdata = v;
        step(1);
        mcr_we    = 1'b0;
    endtask

    task automatic clear_msr();
        msr_re = 1'b1;
        step(1);
        msr_re = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            cyc++;
            if (tx_start === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset_initial();
        #2 RESET = 1'b1;
        step(1);
        nChecks++;
        if (mcr !== 6'h00) $display("FAIL reset_mcr: got %h, required 00", mcr); else nPass++;
        nChecks++;
        if (msr_rdata !== 8'h00) $display("FAIL reset_msr: got %h, required 00", msr_rdata); else nPass++;
        nChecks++;
        if ({modem_int, tx_start, tx_stalled} !== 3'b000)
            $display("FAIL reset_flags: got %b, required 000", {modem_int, tx_start, tx_stalled});
        else nPass++;
        nChecks++;
        if ({nRTS, nDTR, OUT1, OUT2} !== 4'hF)
            $display("FAIL reset_pins: got %h, required f", {nRTS, nDTR, OUT1, OUT2});
        else nPass++;
        step(1);
        RESET = 1'b0;
        step(2);
        nChecks++;
        if ({msr_rdata, nRTS, nDTR, OUT1, OUT2} !== 12'h00F)
            $display("FAIL post_reset_idle: got %h, required 00f", {msr_rdata, nRTS, nDTR, OUT1, OUT2});
        else nPass++;
    endtask

    task automatic test_status();
        nCTS = 1'b0;
        step(2);
        nChecks++;
        if (msr_rdata !== 8'h10) $display("FAIL cts_status_2edges: got %h, required 10", msr_rdata); else nPass++;
        step(1);
        nChecks++;
        if (msr_rdata !== 8'h11) $display("FAIL dcts_3edges: got %h, required 11", msr_rdata); else nPass++;
        nChecks++;
        if (modem_int !== 1'b1) $display("FAIL int_set: got %b, required 1", modem_int); else nPass++;
        clear_msr();
        nChecks++;
        if ({msr_rdata, modem_int} !== 9'h020)
            $display("FAIL msr_clear: got %h, required 020 (msr 10, int 0)", {msr_rdata, modem_int});
        else nPass++;
        nDSR = 1'b0;
        step(2);
        nChecks++;
        if (msr_rdata !== 8'h30) $display("FAIL dsr_status: got %h, required 30", msr_rdata); else nPass++;
        msr_re = 1'b1;
        step(1);
        msr_re = 1'b0;
        nChecks++;
        if (msr_rdata !== 8'h32) $display("FAIL ddsr_wins_clear: got %h, required 32", msr_rdata); else nPass++;
        nCTS = 1'b1;
        nDSR = 1'b1;
        step(3);
        clear_msr();
        nChecks++;
        if (msr_rdata !== 8'h00) $display("FAIL status_release: got %h, required 00", msr_rdata); else nPass++;
    endtask

    task automatic test_teri();
        nRI = 1'b0;
        step(3);
        nChecks++;
        if (msr_rdata !== 8'h40) $display("FAIL teri_ri_rise: got %h, required 40", msr_rdata); else nPass++;
        nRI = 1'b1;
        step(3);
        nChecks++;
        if ({msr_rdata, modem_int} !== 9'h009)
            $display("FAIL teri_ri_fall: got %h, required 009 (msr 04, int 1)", {msr_rdata, modem_int});
        else nPass++;
    endtask

    task automatic test_loopback();
        write_mcr(6'h0F);
        nChecks++;
        if ({mcr, nRTS, nDTR, OUT1, OUT2} !== 10'h0FF)
            $display("FAIL mcr_write_edge: got %h, required 0ff (mcr 0f, pins f)", {mcr, nRTS, nDTR, OUT1, OUT2});
        else nPass++;
        step(1);
        nChecks++;
        if ({nRTS, nDTR, OUT1, OUT2} !== 4'h0)
            $display("FAIL pins_next_edge: got %h, required 0", {nRTS, nDTR, OUT1, OUT2});
        else nPass++;
        write_mcr(6'h1F);
        step(1);
        nChecks++;
        if ({nRTS, nDTR, OUT1, OUT2} !== 4'hF)
            $display("FAIL loop_pins_forced: got %h, required f", {nRTS, nDTR, OUT1, OUT2});
        else nPass++;
        step(2);
        nChecks++;
        if (msr_rdata !== 8'hFF) $display("FAIL loop_msr_on: got %h, required ff", msr_rdata); else nPass++;
        clear_msr();
        nChecks++;
        if (msr_rdata !== 8'hF0) $display("FAIL loop_msr_clear: got %h, required f0", msr_rdata); else nPass++;
        write_mcr(6'h10);
        step(3);
        nChecks++;
        if (msr_rdata !== 8'h0F) $display("FAIL loop_msr_off: got %h, required 0f", msr_rdata); else nPass++;
        write_mcr(6'h00);
        step(3);
        clear_msr();
        nChecks++;
        if (msr_rdata !== 8'h00) $display("FAIL loop_exit: got %h, required 00", msr_rdata); else nPass++;
    endtask

    task automatic test_auto_rts();
        logic expFlow;
        logic expNrts;
        int   lvl;
        write_mcr(6'h22);
        step(1);
        nChecks++;
        if (nRTS !== 1'b0) $display("FAIL afe_rts_on: got %b, required 0", nRTS); else nPass++;
        expFlow = 1'b1;
        for (int i = 0; i < 31; i++) begin
            lvl      = (i < 16) ? i : 30 - i;
            rx_level = 5'(lvl);
            expNrts  = ~expFlow;
            if (lvl >= 14) expFlow = 1'b0;
            else if (lvl <= 8) expFlow = 1'b1;
            step(1);
            nChecks++;
            if (nRTS !== expNrts)
                $display("FAIL auto_rts step %0d level %0d: got %b, required %b", i, lvl, nRTS, expNrts);
            else nPass++;
        end
        rx_level = 5'd0;
        step(2);
    endtask

    task automatic test_cts_flow();
        bit seen;
        int cyc;
        write_mcr(6'h20);
        tx_req = 1'b1;
        step(1);
        nChecks++;
        if (tx_stalled !== 1'b1) $display("FAIL cts_stall: got %b, required 1", tx_stalled); else nPass++;
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
        step(2);
        nChecks++;
        if (tx_stalled !== 1'b1) $display("FAIL done_in_stall: got %b, required 1", tx_stalled); else nPass++;
        expStartQ.push_back(1);
        nCTS = 1'b0;
        wait_start(10, seen, cyc);
        nChecks++;
        if (!seen) $display("FAIL cts_start_timeout: got no start in %0d cycles, required one", cyc); else nPass++;
        nCTS = 1'b1;
        step(4);
        nChecks++;
        if (tx_stalled !== 1'b0) $display("FAIL busy_not_aborted: got %b, required 0", tx_stalled); else nPass++;
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
        step(1);
        nChecks++;
        if (tx_stalled !== 1'b1) $display("FAIL stall_after_done: got %b, required 1", tx_stalled); else nPass++;
        nChecks++;
        if (expStartQ.size() != 0) $display("FAIL cts_pending: got %0d pending, required 0", expStartQ.size()); else nPass++;
    endtask

    task automatic test_back_to_back();
        bit seen;
        int cyc;
        write_mcr(6'h00);
        for (int k = 0; k < 3; k++) begin
            expStartQ.push_back(k);
            wait_start(8, seen, cyc);
            nChecks++;
            if (!seen) $display("FAIL b2b_timeout %0d: got no start, required one", k); else nPass++;
            if (k > 0) begin
                nChecks++;
                if (cyc != 1) $display("FAIL b2b_spacing %0d: got %0d cycles, required 1", k, cyc); else nPass++;
            end
            step(1);
            tx_done = 1'b1;
            if (k == 2) tx_req = 1'b0;
            step(1);
            tx_done = 1'b0;
            nChecks++;
            if (tx_start !== 1'b0) $display("FAIL b2b_idle_gap %0d: got %b, required 0", k, tx_start); else nPass++;
        end
        step(3);
        nChecks++;
        if ({expStartQ.size() != 0, tx_stalled} !== 2'b00)
            $display("FAIL b2b_end: got pending %0d stalled %b, required 0 0", expStartQ.size(), tx_stalled);
        else nPass++;
    endtask

    task automatic test_reset_busy();
        bit seen;
        int cyc;
        write_mcr(6'h0F);
        nCTS = 1'b0;
        step(3);
        nChecks++;
        if (modem_int !== 1'b1) $display("FAIL pre_reset_delta: got %b, required 1", modem_int); else nPass++;
        tx_req = 1'b1;
        expStartQ.push_back(10);
        wait_start(8, seen, cyc);
        nChecks++;
        if (!seen) $display("FAIL pre_reset_start: got no start, required one"); else nPass++;
        step(1);
        RESET = 1'b1;
        #1;
        nChecks++;
        if ({mcr, msr_rdata} !== 14'h0000)
            $display("FAIL busy_reset_regs: got mcr %h msr %h, required 00 00", mcr, msr_rdata);
        else nPass++;
        nChecks++;
        if ({modem_int, tx_start, tx_stalled, nRTS, nDTR, OUT1, OUT2} !== 7'b0001111)
            $display("FAIL busy_reset_outs: got %b, required 0001111",
                     {modem_int, tx_start, tx_stalled, nRTS, nDTR, OUT1, OUT2});
        else nPass++;
        step(3);
        nChecks++;
        if (tx_start !== 1'b0) $display("FAIL start_in_reset: got %b, required 0", tx_start); else nPass++;
        expStartQ.push_back(11);
        RESET = 1'b0;
        wait_start(4, seen, cyc);
        nChecks++;
        if (!seen) $display("FAIL post_reset_start: got no start, required one"); else nPass++;
        step(1);
        tx_done = 1'b1;
        tx_req  = 1'b0;
        step(1);
        tx_done = 1'b0;
        nCTS    = 1'b1;
        step(3);
        nChecks++;
        if (expStartQ.size() != 0) $display("FAIL reset_pending: got %0d pending, required 0", expStartQ.size()); else nPass++;
    endtask

    initial begin
        test_reset_initial();
        test_status();
        test_teri();
        test_loopback();
        test_auto_rts();
        test_cts_flow();
        test_back_to_back();
        test_reset_busy();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/modem_ctrl.md
# modem_ctrl

Modem control/status controller for the UART: holds the Modem Control Register (MCR), builds the Modem Status Register (MSR) with delta tracking and a modem interrupt, and sequences transmit-character starts under CTS auto-flow control. It sits between the register-access logic and the UART transmitter/receiver FIFOs on one side, and the modem interface pins on the other.

## Interface
- RX_LVL_W, 5: width of the RX FIFO level input.
- RTS_OFF_LVL, 14: RX level at or above which auto-flow deasserts RTS.
- RTS_ON_LVL, 8: RX level at or below which auto-flow reasserts RTS; must be < RTS_OFF_LVL.

- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- mcr_we  in  1  MCR write strobe.
- mcr_wdata  in  6  [0]DTR [1]RTS [2]OUT1 [3]OUT2 [4]LOOP [5]AFE.
- mcr  out  6  MCR readback.
- msr_re  in  1  MSR read strobe; clears delta bits.
- msr_rdata  out  8  [7]DCD [6]RI [5]DSR [4]CTS [3]DDCD [2]TERI [1]DDSR [0]DCTS.
- modem_int  out  1  OR of MSR[3:0].
- rx_level  in  RX_LVL_W  RX FIFO occupancy.
- tx_req  in  1  TX FIFO non-empty.
- tx_start  out  1  one-cycle pulse: transmitter may start a character.
- tx_done  in  1  one-cycle pulse: current character fully shifted out.
- tx_stalled  out  1  high while FSM is in STALL.
- nCTS, nDSR, nRI, nDCD  in  1 each  asynchronous active-low modem inputs.
- nRTS, nDTR, OUT1, OUT2  out  1 each  modem outputs, registered.

## Operation
- MCR: mcr_we loads mcr_wdata on the edge; reset 6'h00.
- Input path: each n-input goes through a mux (pin, or loopback source when LOOP=1) then a 2-flop synchronizer reset to 1 (inactive). Status = inverted sync2: CTS, DSR, RI, DCD.
- Loopback sources: CTS<-MCR.RTS, DSR<-MCR.DTR, RI<-MCR.OUT1, DCD<-MCR.OUT2 (active-high bits drive inverted n-signal).
- Delta: third flop holds previous status. DCTS/DDSR/DDCD set on any change; TERI set only on RI 1->0. Deltas sticky until cleared.
- msr_re clears MSR[3:0] on the next edge; a delta set in the same cycle wins (bit stays 1).
- Outputs: nDTR = ~DTR, nRTS = ~(RTS & flow_ok), OUT1 = ~MCR.OUT1, OUT2 = ~MCR.OUT2; when LOOP=1 all four are forced to 1. Registered; reset value 1.
- flow_ok (AFE=1): cleared when rx_level >= RTS_OFF_LVL, set when rx_level <= RTS_ON_LVL, otherwise held (hysteresis). AFE=0 forces flow_ok=1. Reset 1.
- tx_allow = ~AFE | CTS.
- TX FSM, states IDLE/BUSY/STALL, reset IDLE:
  - IDLE: tx_req & tx_allow -> pulse tx_start, go BUSY; tx_req & ~tx_allow -> STALL.
  - BUSY: on tx_done -> IDLE. CTS loss does not abort the character in flight.
  - STALL: tx_allow -> IDLE; ~tx_req -> IDLE.
- tx_done outside BUSY is ignored.

## Timing
- Reset values: mcr=0, msr_rdata=8'h00, modem_int=0, tx_start=0, tx_stalled=0, nRTS=nDTR=OUT1=OUT2=1.
- Pin edge sampled at edge 0: status bit visible after edge 2; delta bit and modem_int after edge 3.
- MCR write at edge N: mcr updates at N, pins update at N+1.
- Loopback path has the same latency as the pin path, since the mux sits before the synchronizer.
- rx_level crossing threshold at edge N: flow_ok updates at N, nRTS at N+1.
- tx_start is high exactly one cycle. Minimum spacing between starts: tx_done cycle, one IDLE cycle, then the start.
- RESET mid-character: FSM returns to IDLE; no tx_start until RESET drops and tx_req & tx_allow hold.
- Setting LOOP with pins idle generates deltas whenever loop sources differ from pin values. This behaviour is required and matches the 16550.

## Test plan
- Reset: assert RESET mid-BUSY with deltas set -> all outputs at reset values; msr_rdata=8'h00; tx_start stays 0.
- Status/delta: drive nCTS 1->0 -> MSR[4]=1 after 2 edges, MSR[0]=1 and modem_int=1 after 3; msr_re -> MSR=8'h10, modem_int=0. Repeat with msr_re coinciding with an nDSR change -> DDSR remains 1.
- TERI: nRI 1->0 -> TERI stays 0; nRI 0->1 -> TERI=1.
- Loopback: write 6'h1F -> all four pins=1; MSR[7:4]=4'hF, MSR[3:0]=4'hF. Then write 6'h10 -> MSR[7:4]=0.
- Auto-RTS: write 6'h22, sweep rx_level 0->15->0 -> nRTS rises one cycle after level hits 14, stays 1 for levels 13..9, falls one cycle after level hits 8.
- CTS flow: AFE=1, tx_req=1, nCTS=1 -> tx_stalled=1, no tx_start. Drop nCTS -> one tx_start pulse. Raise nCTS during BUSY -> character completes on tx_done, then STALL.
